// File: rtl/backend_cmd_adapter.sv
// Frontend-to-Ctrl command adapter: buffered command FIFO with auto-precharge
// prediction, credit-gated read issue and a read-return FIFO toward the frontend.
module backend_cmd_adapter #(
  parameter int ROW_BITS    = 16,
  parameter int COL_BITS    = 10,
  parameter int BANK_BITS   = 3,
  parameter int DATA_BITS   = 128,
  parameter int CMD_DEPTH   = 4,
  parameter int RDATA_DEPTH = 4,
  parameter int AP_MODE     = 2
) (
  input  logic                               clk,
  input  logic                               power_on_rst_n,
  input  logic                               i_frontend_command_valid,
  output logic                               o_backend_controller_ready,
  input  logic                               i_frontend_op,
  input  logic [ROW_BITS-1:0]                i_frontend_row_addr,
  input  logic [COL_BITS-1:0]                i_frontend_col_addr,
  input  logic [BANK_BITS-1:0]               i_frontend_bank_addr,
  input  logic [DATA_BITS-1:0]               i_frontend_write_data,
  output logic                               o_ctrl_valid,
  input  logic                               i_ctrl_ready,
  output logic                               o_ctrl_rw,
  output logic [ROW_BITS-1:0]                o_ctrl_row_addr,
  output logic [COL_BITS-1:0]                o_ctrl_col_addr,
  output logic [BANK_BITS-1:0]               o_ctrl_bank_addr,
  output logic                               o_ctrl_auto_precharge,
  output logic [DATA_BITS-1:0]               o_ctrl_write_data,
  input  logic [DATA_BITS-1:0]               i_ctrl_read_data,
  input  logic                               i_ctrl_read_data_valid,
  output logic [DATA_BITS-1:0]               o_backend_read_data,
  output logic                               o_backend_read_data_valid,
  input  logic                               i_frontend_controller_ready,
  output logic [$clog2(RDATA_DEPTH+1)-1:0]   o_outstanding_reads,
  output logic                               o_protocol_err
);

  localparam int CW       = $clog2(CMD_DEPTH);
  localparam int RW       = (RDATA_DEPTH > 1) ? $clog2(RDATA_DEPTH) : 1;
  localparam int OW       = $clog2(RDATA_DEPTH + 1);
  localparam int BANK_LSB = DATA_BITS;
  localparam int COL_LSB  = BANK_LSB + BANK_BITS;
  localparam int ROW_LSB  = COL_LSB + COL_BITS;
  localparam int OP_BIT   = ROW_LSB + ROW_BITS;
  localparam int EW       = OP_BIT + 1;

  logic [EW-1:0]        cmd_mem [CMD_DEPTH];
  logic [CW-1:0]        cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CW:0]          cmd_cnt_q, cmd_cnt_d;
  logic [EW-1:0]        head, next_entry;
  logic                 cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic                 credit_ok, ap_lookahead, ap_flag, read_issue;
  logic [OW:0]          credit_sum;

  logic [DATA_BITS-1:0] rd_mem [RDATA_DEPTH];
  logic [RW-1:0]        rd_wr_ptr_q, rd_wr_ptr_d, rd_rd_ptr_q, rd_rd_ptr_d;
  logic [OW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [OW-1:0]        out_q, out_d;
  logic                 err_q, err_d;
  logic                 rd_full, rd_push, rd_pop;

  function automatic logic [RW-1:0] rd_inc(input logic [RW-1:0] p);
    return (p == RW'(RDATA_DEPTH - 1)) ? '0 : p + RW'(1);
  endfunction

  assign cmd_empty  = (cmd_cnt_q == '0);
  assign cmd_full   = (cmd_cnt_q == (CW+1)'(CMD_DEPTH));
  assign head       = cmd_mem[cmd_rd_ptr_q];
  assign next_entry = cmd_mem[cmd_rd_ptr_q + CW'(1)];

  // Buffered return data consumes credit just like in-flight reads.
  assign credit_sum = {1'b0, out_q} + {1'b0, rd_cnt_q};
  assign credit_ok  = (credit_sum < (OW+1)'(RDATA_DEPTH));

  assign o_backend_controller_ready = !cmd_full;
  assign cmd_push   = i_frontend_command_valid && !cmd_full;
  assign o_ctrl_valid = !cmd_empty && (head[OP_BIT] || credit_ok);
  assign cmd_pop    = o_ctrl_valid && i_ctrl_ready;
  assign read_issue = cmd_pop && !head[OP_BIT];

  // Close the row only when the very next command would conflict in the same bank.
  assign ap_lookahead = (cmd_cnt_q >= (CW+1)'(2)) &&
                        (next_entry[BANK_LSB +: BANK_BITS] == head[BANK_LSB +: BANK_BITS]) &&
                        (next_entry[ROW_LSB +: ROW_BITS] != head[ROW_LSB +: ROW_BITS]);

  always_comb begin
    ap_flag = 1'b0;
    if (AP_MODE == 1)      ap_flag = 1'b1;
    else if (AP_MODE == 2) ap_flag = ap_lookahead;
  end

  assign o_ctrl_rw             = !cmd_empty && head[OP_BIT];
  assign o_ctrl_row_addr       = cmd_empty ? '0 : head[ROW_LSB +: ROW_BITS];
  assign o_ctrl_col_addr       = cmd_empty ? '0 : head[COL_LSB +: COL_BITS];
  assign o_ctrl_bank_addr      = cmd_empty ? '0 : head[BANK_LSB +: BANK_BITS];
  assign o_ctrl_write_data     = cmd_empty ? '0 : head[DATA_BITS-1:0];
  assign o_ctrl_auto_precharge = !cmd_empty && ap_flag;

  always_comb begin
    cmd_wr_ptr_d = cmd_push ? cmd_wr_ptr_q + CW'(1) : cmd_wr_ptr_q;
    cmd_rd_ptr_d = cmd_pop  ? cmd_rd_ptr_q + CW'(1) : cmd_rd_ptr_q;
    cmd_cnt_d    = cmd_cnt_q;
    if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + (CW+1)'(1);
    else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - (CW+1)'(1);
  end

  assign rd_full = (rd_cnt_q == OW'(RDATA_DEPTH));
  assign o_backend_read_data_valid = (rd_cnt_q != '0);
  assign o_backend_read_data = o_backend_read_data_valid ? rd_mem[rd_rd_ptr_q] : '0;
  assign rd_pop  = o_backend_read_data_valid && i_frontend_controller_ready;
  assign rd_push = i_ctrl_read_data_valid && (!rd_full || rd_pop);

  always_comb begin
    rd_wr_ptr_d = rd_push ? rd_inc(rd_wr_ptr_q) : rd_wr_ptr_q;
    rd_rd_ptr_d = rd_pop  ? rd_inc(rd_rd_ptr_q) : rd_rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    if (rd_push && !rd_pop)      rd_cnt_d = rd_cnt_q + OW'(1);
    else if (!rd_push && rd_pop) rd_cnt_d = rd_cnt_q - OW'(1);

    out_d = out_q;
    if (read_issue && !i_ctrl_read_data_valid)
      out_d = out_q + OW'(1);
    else if (!read_issue && i_ctrl_read_data_valid && out_q != '0)
      out_d = out_q - OW'(1);

    err_d = err_q ||
            (i_ctrl_read_data_valid && out_q == '0) ||
            (i_ctrl_read_data_valid && rd_full && !rd_pop);
  end

  assign o_outstanding_reads = out_q;
  assign o_protocol_err      = err_q;

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wr_ptr_q] <= {i_frontend_op, i_frontend_row_addr, i_frontend_col_addr,
                                i_frontend_bank_addr, i_frontend_write_data};
    if (rd_push)
      rd_mem[rd_wr_ptr_q] <= i_ctrl_read_data;
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
      rd_wr_ptr_q  <= '0;
      rd_rd_ptr_q  <= '0;
      rd_cnt_q     <= '0;
      out_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      cmd_cnt_q    <= cmd_cnt_d;
      rd_wr_ptr_q  <= rd_wr_ptr_d;
      rd_rd_ptr_q  <= rd_rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      out_q        <= out_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_backend_cmd_adapter.sv
// Bench for backend_cmd_adapter: three instances (AP_MODE 2/0/1) share one stimulus
// stream; a queue-based model predicts every output each cycle.
module tb_backend_cmd_adapter;

  typedef struct packed {
    logic         op;
    logic [15:0]  row;
    logic [9:0]   col;
    logic [2:0]   bank;
    logic [127:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         fe_valid = 0, fe_op = 0, ctrl_ready = 0, rdv = 0, fe_ready = 0;
  logic [15:0]  fe_row = 0;
  logic [9:0]   fe_col = 0;
  logic [2:0]   fe_bank = 0;
  logic [127:0] fe_wdata = 0, rdata_in = 0;

  logic         ready, cvalid, crw, cap, rvalid, err;
  logic [15:0]  crow;
  logic [9:0]   ccol;
  logic [2:0]   cbank;
  logic [127:0] cwdata, rdata_out;
  logic [2:0]   outst;

  logic         a0_ready, a0_cvalid, a0_crw, a0_cap, a0_rvalid, a0_err;
  logic [15:0]  a0_crow;
  logic [9:0]   a0_ccol;
  logic [2:0]   a0_cbank, a0_outst;
  logic [127:0] a0_cwdata, a0_rdata;
  logic         a1_ready, a1_cvalid, a1_crw, a1_cap, a1_rvalid, a1_err;
  logic [15:0]  a1_crow;
  logic [9:0]   a1_ccol;
  logic [2:0]   a1_cbank, a1_outst;
  logic [127:0] a1_cwdata, a1_rdata;

  backend_cmd_adapter #(.AP_MODE(2)) u_dut (
    .clk(clk), .power_on_rst_n(rst_n),
    .i_frontend_command_valid(fe_valid), .o_backend_controller_ready(ready),
    .i_frontend_op(fe_op), .i_frontend_row_addr(fe_row), .i_frontend_col_addr(fe_col),
    .i_frontend_bank_addr(fe_bank), .i_frontend_write_data(fe_wdata),
    .o_ctrl_valid(cvalid), .i_ctrl_ready(ctrl_ready), .o_ctrl_rw(crw),
    .o_ctrl_row_addr(crow), .o_ctrl_col_addr(ccol), .o_ctrl_bank_addr(cbank),
    .o_ctrl_auto_precharge(cap), .o_ctrl_write_data(cwdata),
    .i_ctrl_read_data(rdata_in), .i_ctrl_read_data_valid(rdv),
    .o_backend_read_data(rdata_out), .o_backend_read_data_valid(rvalid),
    .i_frontend_controller_ready(fe_ready), .o_outstanding_reads(outst),
    .o_protocol_err(err));

  backend_cmd_adapter #(.AP_MODE(0)) u_ap0 (
    .clk(clk), .power_on_rst_n(rst_n),
    .i_frontend_command_valid(fe_valid), .o_backend_controller_ready(a0_ready),
    .i_frontend_op(fe_op), .i_frontend_row_addr(fe_row), .i_frontend_col_addr(fe_col),
    .i_frontend_bank_addr(fe_bank), .i_frontend_write_data(fe_wdata),
    .o_ctrl_valid(a0_cvalid), .i_ctrl_ready(ctrl_ready), .o_ctrl_rw(a0_crw),
    .o_ctrl_row_addr(a0_crow), .o_ctrl_col_addr(a0_ccol), .o_ctrl_bank_addr(a0_cbank),
    .o_ctrl_auto_precharge(a0_cap), .o_ctrl_write_data(a0_cwdata),
    .i_ctrl_read_data(rdata_in), .i_ctrl_read_data_valid(rdv),
    .o_backend_read_data(a0_rdata), .o_backend_read_data_valid(a0_rvalid),
    .i_frontend_controller_ready(fe_ready), .o_outstanding_reads(a0_outst),
    .o_protocol_err(a0_err));

  backend_cmd_adapter #(.AP_MODE(1)) u_ap1 (
    .clk(clk), .power_on_rst_n(rst_n),
    .i_frontend_command_valid(fe_valid), .o_backend_controller_ready(a1_ready),
    .i_frontend_op(fe_op), .i_frontend_row_addr(fe_row), .i_frontend_col_addr(fe_col),
    .i_frontend_bank_addr(fe_bank), .i_frontend_write_data(fe_wdata),
    .o_ctrl_valid(a1_cvalid), .i_ctrl_ready(ctrl_ready), .o_ctrl_rw(a1_crw),
    .o_ctrl_row_addr(a1_crow), .o_ctrl_col_addr(a1_ccol), .o_ctrl_bank_addr(a1_cbank),
    .o_ctrl_auto_precharge(a1_cap), .o_ctrl_write_data(a1_cwdata),
    .i_ctrl_read_data(rdata_in), .i_ctrl_read_data_valid(rdv),
    .o_backend_read_data(a1_rdata), .o_backend_read_data_valid(a1_rvalid),
    .i_frontend_controller_ready(fe_ready), .o_outstanding_reads(a1_outst),
    .o_protocol_err(a1_err));

  // Reference model state: plain queues and counters.
  cmd_t         cq[$];
  logic [127:0] rq[$];
  int           m_out = 0;
  bit           m_err = 0;
  bit           last_push = 0;
  logic         ap2_log[$], ap0_log[$], ap1_log[$];
  int           checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, 128'(ready), 128'(1));
    chk({p, "_cvalid"}, 128'(cvalid), 128'(0));
    chk({p, "_fields"}, 128'({crw, crow, ccol, cbank, cap}), 128'(0));
    chk({p, "_wdata"}, cwdata, 128'(0));
    chk({p, "_rvalid"}, 128'(rvalid), 128'(0));
    chk({p, "_rdata"}, rdata_out, 128'(0));
    chk({p, "_outst"}, 128'(outst), 128'(0));
    chk({p, "_err"}, 128'(err), 128'(0));
  endtask

  // One clock: check settled outputs against the model, then advance the model.
  task automatic cycle();
    cmd_t h, n;
    bit   exp_ready, exp_cv, exp_ap, push, pop, rpop, rissue;
    int   o_pre, rq_pre;
    #1;
    exp_ready = cq.size() < 4;
    exp_cv    = cq.size() > 0 && (cq[0].op || (m_out + rq.size()) < 4);
    h = (cq.size() > 0) ? cq[0] : '0;
    exp_ap = cq.size() >= 2 && cq[1].bank == cq[0].bank && cq[1].row != cq[0].row;
    chk("ready", 128'(ready), 128'(exp_ready));
    chk("ctrl_valid", 128'(cvalid), 128'(exp_cv));
    chk("ctrl_rw", 128'(crw), 128'(h.op));
    chk("ctrl_row", 128'(crow), 128'(h.row));
    chk("ctrl_col", 128'(ccol), 128'(h.col));
    chk("ctrl_bank", 128'(cbank), 128'(h.bank));
    chk("ctrl_wdata", cwdata, h.data);
    chk("ap2", 128'(cap), 128'(exp_ap));
    chk("ap0", 128'(a0_cap), 128'(0));
    chk("ap1", 128'(a1_cap), 128'(cq.size() > 0));
    chk("rvalid", 128'(rvalid), 128'(rq.size() > 0));
    chk("rdata", rdata_out, (rq.size() > 0) ? rq[0] : 128'(0));
    chk("outstanding", 128'(outst), 128'(m_out));
    chk("perr", 128'(err), 128'(m_err));
    push = fe_valid && exp_ready;
    pop  = exp_cv && ctrl_ready;
    rpop = rq.size() > 0 && fe_ready;
    if (pop) begin
      ap2_log.push_back(cap);
      ap0_log.push_back(a0_cap);
      ap1_log.push_back(a1_cap);
    end
    n = '{op: fe_op, row: fe_row, col: fe_col, bank: fe_bank, data: fe_wdata};
    o_pre  = m_out;
    rq_pre = rq.size();
    @(posedge clk);
    rissue = pop && !cq[0].op;
    if (pop) void'(cq.pop_front());
    if (push) cq.push_back(n);
    last_push = push;
    if (rissue && !rdv) m_out++;
    else if (!rissue && rdv && m_out > 0) m_out--;
    if (rdv && o_pre == 0) m_err = 1;
    if (rdv && rq_pre == 4 && !rpop) m_err = 1;
    if (rpop) void'(rq.pop_front());
    if (rdv && (rq_pre < 4 || rpop)) rq.push_back(rdata_in);
    #1;
  endtask

  task automatic push_cmd(input bit op, input logic [15:0] row, input logic [2:0] bank);
    int n = 0;
    fe_valid = 1; fe_op = op; fe_row = row; fe_bank = bank;
    fe_col = 10'($urandom); fe_wdata = {$urandom, $urandom, $urandom, $urandom};
    do begin cycle(); n++; end while (!last_push && n < 50);
    if (!last_push) chk("push_timeout", 128'(ready), 128'(1));
    fe_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    fe_valid = 0; ctrl_ready = 1; fe_ready = 1;
    while ((cq.size() > 0 || m_out > 0 || rq.size() > 0) && n < 300) begin
      rdv = (m_out > 0);
      rdata_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      n++;
    end
    rdv = 0;
    if (n >= 300) chk("drain_timeout", 128'(outst), 128'(0));
  endtask

  initial begin
    logic [127:0] a5;
    a5 = {16{8'hA5}};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1;
    cycle();

    // Fill with four writes while Ctrl stalls, then drain in order.
    ctrl_ready = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'($urandom), 3'($urandom));
    chk("full_ready", 128'(ready), 128'(0));
    chk("full_head_rw", 128'(crw), 128'(1));
    ctrl_ready = 1;
    repeat (5) cycle();
    chk("drained_valid", 128'(cvalid), 128'(0));

    // Auto-precharge lookahead stream.
    ctrl_ready = 0;
    push_cmd(1'b1, 16'd5, 3'd0);
    push_cmd(1'b1, 16'd7, 3'd0);
    push_cmd(1'b1, 16'd7, 3'd1);
    push_cmd(1'b1, 16'd7, 3'd1);
    ap2_log.delete(); ap0_log.delete(); ap1_log.delete();
    ctrl_ready = 1;
    repeat (6) cycle();
    chk("ap_issue_count", 128'(ap2_log.size()), 128'(4));
    for (int i = 0; i < ap2_log.size(); i++) begin
      chk($sformatf("ap2_issue%0d", i), 128'(ap2_log[i]), 128'(i == 0));
      chk($sformatf("ap0_issue%0d", i), 128'(ap0_log[i]), 128'(0));
      chk($sformatf("ap1_issue%0d", i), 128'(ap1_log[i]), 128'(1));
    end

    // Credit gating: six reads, frontend not accepting, Ctrl silent.
    ctrl_ready = 1; fe_ready = 0;
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 16'($urandom), 3'($urandom));
    repeat (3) cycle();
    chk("credit_outst4", 128'(outst), 128'(4));
    rdv = 1;
    for (int i = 0; i < 2; i++) begin
      rdata_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rdv = 0;
    repeat (3) cycle();
    chk("credit_outst2", 128'(outst), 128'(2));
    chk("credit_blocked", 128'(cvalid), 128'(0));
    fe_ready = 1;
    cycle();
    fe_ready = 0;
    repeat (3) cycle();
    chk("credit_outst3", 128'(outst), 128'(3));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      fe_valid   = 1'($urandom);
      fe_op      = 1'($urandom);
      fe_row     = 16'($urandom_range(0, 2));
      fe_col     = 10'($urandom);
      fe_bank    = 3'($urandom_range(0, 1));
      fe_wdata   = {$urandom, $urandom, $urandom, $urandom};
      ctrl_ready = 1'($urandom);
      fe_ready   = 1'($urandom);
      rdv        = (m_out > 0) && ($urandom_range(0, 2) == 0);
      rdata_in   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rdv = 0;
    drain();

    // Unsolicited read data sets the sticky error but is still buffered.
    fe_ready = 0;
    rdv = 1; rdata_in = a5;
    cycle();
    rdv = 0;
    chk("perr_set", 128'(err), 128'(1));
    chk("perr_rvalid", 128'(rvalid), 128'(1));
    chk("perr_rdata", rdata_out, a5);
    repeat (3) cycle();
    chk("perr_sticky", 128'(err), 128'(1));

    // Mid-operation reset with queued commands and buffered reads.
    fe_ready = 1;
    repeat (2) cycle();
    fe_ready = 0; ctrl_ready = 1;
    push_cmd(1'b0, 16'($urandom), 3'($urandom));
    push_cmd(1'b0, 16'($urandom), 3'($urandom));
    repeat (2) cycle();
    rdv = 1;
    for (int i = 0; i < 2; i++) begin
      rdata_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rdv = 0; ctrl_ready = 0;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 16'($urandom), 3'($urandom));
    chk("pre_rst_rvalid", 128'(rvalid), 128'(1));
    chk("pre_rst_cvalid", 128'(cvalid), 128'(1));
    rst_n = 0;
    #1;
    chk_reset("midrst");
    cq.delete(); rq.delete(); m_out = 0; m_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) cycle();
    chk("post_rst_ready", 128'(ready), 128'(1));
    chk("post_rst_outst", 128'(outst), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backend_cmd_adapter.md
Name: backend_cmd_adapter

Overview:
Parametrised successor to the single-rank frontend-to-Ctrl command translator. It sits between the frontend scheduler and the Ctrl rank engine. Commands and write data are buffered in a CMD_DEPTH-entry FIFO, and each command receives an auto-precharge decision from a selectable predictor. Read data returned from Ctrl is buffered in an RDATA_DEPTH-entry FIFO, and read issue is credit-gated so frontend backpressure can never overflow it.

Parameters:
ROW_BITS, 16, row address width
COL_BITS, 10, column address width
BANK_BITS, 3, bank address width
DATA_BITS, 128, burst data width (DQ_BITS*8)
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RDATA_DEPTH, 4, read-return FIFO entries (power of 2, >=1)
AP_MODE, 2, auto-precharge policy: 0 never, 1 always, 2 lookahead

Ports:
clk  in  1  system clock, rising edge
power_on_rst_n  in  1  asynchronous active-low reset
i_frontend_command_valid  in  1  frontend command valid
o_backend_controller_ready  out  1  adapter can accept a command
i_frontend_op  in  1  0=read, 1=write
i_frontend_row_addr  in  ROW_BITS  row
i_frontend_col_addr  in  COL_BITS  column
i_frontend_bank_addr  in  BANK_BITS  bank
i_frontend_write_data  in  DATA_BITS  write burst, sampled with the command
o_ctrl_valid  out  1  command presented to Ctrl
i_ctrl_ready  in  1  Ctrl accepts (ba_cmd_pm)
o_ctrl_rw  out  1  0=read, 1=write
o_ctrl_row_addr  out  ROW_BITS  row
o_ctrl_col_addr  out  COL_BITS  column
o_ctrl_bank_addr  out  BANK_BITS  bank
o_ctrl_auto_precharge  out  1  auto-precharge flag
o_ctrl_write_data  out  DATA_BITS  write data of the head entry
i_ctrl_read_data  in  DATA_BITS  read burst from Ctrl
i_ctrl_read_data_valid  in  1  read burst valid; no backpressure
o_backend_read_data  out  DATA_BITS  read data to frontend
o_backend_read_data_valid  out  1  read data valid
i_frontend_controller_ready  in  1  frontend accepts read data
o_outstanding_reads  out  $clog2(RDATA_DEPTH+1)  reads issued to Ctrl, data not yet returned
o_protocol_err  out  1  sticky error flag

Behaviour:
- Reset values (asynchronous, power_on_rst_n=0):
  - Both FIFOs empty; outstanding counter 0; o_protocol_err 0.
  - o_backend_controller_ready=1; o_ctrl_valid=0; o_backend_read_data_valid=0.
  - All data, address and flag outputs are 0.
  - Reset mid-operation discards all queued commands, buffered data and credits.
- Command FIFO:
  - o_backend_controller_ready = !cmd_full. This is combinational from the count, and does not depend on a same-cycle pop.
  - Push on valid&&ready. The entry stores op, row, col, bank and write data.
  - A pushed entry is visible at the head no earlier than the next cycle; there is no bypass.
  - Pointers wrap modulo CMD_DEPTH.
  - Simultaneous push and pop keep the count unchanged.
- Ctrl handshake:
  - o_ctrl_* fields reflect the head entry whenever the FIFO is non-empty.
  - Fields are 0 when the FIFO is empty.
  - Pop on o_ctrl_valid&&i_ctrl_ready.
  - o_ctrl_valid = !cmd_empty && (head is a write || credit_ok).
  - credit_ok = (outstanding + rdata_count) < RDATA_DEPTH.
  - A blocked read head stalls all later commands; order is strictly in-order.
- Auto-precharge policy (evaluated combinationally on the head entry):
  - AP_MODE 0: flag is 0.
  - AP_MODE 1: flag is 1.
  - AP_MODE 2: flag is 1 iff entry head+1 exists, has the same bank, and has a different row. Otherwise the flag is 0, and the row stays open.
- Outstanding read counter:
  - +1 on a read pop; -1 on i_ctrl_read_data_valid.
  - Both in the same cycle leave it unchanged.
  - It saturates at 0.
- Read-return FIFO:
  - Push on i_ctrl_read_data_valid.
  - o_backend_read_data_valid asserts the cycle after the push, and data is held stable until accepted.
  - Pop on valid&&i_frontend_controller_ready.
  - Simultaneous push and pop are allowed when full.
- Errors:
  - o_protocol_err is set and held until reset if i_ctrl_read_data_valid arrives while outstanding==0.
  - It is likewise set if a push arrives while the read FIFO is full and not popping. That data is dropped.
- Latency:
  - Frontend command to o_ctrl_valid: 1 cycle minimum.
  - Ctrl read data to o_backend_read_data_valid: 1 cycle.

Test Plan:
- Reset, then push 4 writes with i_ctrl_ready=0: ready goes 0 after the 4th push and o_ctrl_valid=1 with the head equal to write #0. Raise i_ctrl_ready: four pops in order over 4 cycles, and ready returns to 1 the cycle after the first pop.
- AP_MODE=2, queue bank0/row5, bank0/row7, bank1/row7, bank1/row7: flags on issue are 1, 0, 0, 0.
- AP_MODE=0 and AP_MODE=1 with the same stream: flags are all 0, then all 1.
- RDATA_DEPTH=4, issue 6 reads, i_frontend_controller_ready=0, no Ctrl data: exactly 4 reads pop and o_outstanding_reads=4. Return 2 bursts: still 0 further issues, since the credit is consumed by buffered data. Pop 1 burst to the frontend: 1 more read issues.
- Read data 0xA5..A5 arriving while outstanding=0: o_protocol_err goes 1 and stays 1 until reset, and the FIFO push proceeds.
- Assert power_on_rst_n=0 with 3 queued commands and 2 buffered reads: all outputs are at reset values immediately. After release, ready=1, valid outputs are 0, and o_outstanding_reads=0.
